// File: rtl/cache_axi_bridge.sv
// Converts data-cache write-back and refill requests into single-beat AXI4 transactions, write-back first.
// Optional watchdog on every AXI wait state is enabled by defining CACHE_AXI_TIMEOUT_EN.
module cache_axi_bridge #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_w_ena,
  input  logic [ADDR_W-1:0] req_waddr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_r_ena,
  input  logic [ADDR_W-1:0] req_raddr,
  output logic [DATA_W-1:0] rdata_out,
  output logic              r_valid_out,
  output logic              busy_out,
  output logic              err_out,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic [7:0]        awlen,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wstrb,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic [7:0]        arlen,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp
);

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP, DONE} state_e;

  state_e              state_q, state_d;
  logic                rdPend_q, rdPend_d;
  logic                awDone_q, awDone_d;
  logic                wDone_q, wDone_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                timeout;
  logic                awDoneNext, wDoneNext;

`ifdef CACHE_AXI_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tmoCnt_q;

  // Restarts on every state change so each wait state gets its own full budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    tmoCnt_q <= '0;
    else if (state_d != state_q) tmoCnt_q <= '0;
    else                         tmoCnt_q <= tmoCnt_q + 32'd1;
  end

  assign timeout = (state_q inside {WREQ, WRESP, RREQ, RRESP}) && (tmoCnt_q == TMO_LAST);
`else
  localparam int unusedTimeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rdPend_q <= 1'b0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdPend_q <= rdPend_d;
      awDone_q <= awDone_d;
      wDone_q  <= wDone_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign awDoneNext = awDone_q | (awvalid & awready);
  assign wDoneNext  = wDone_q | (wvalid & wready);

  always_comb begin
    state_d  = state_q;
    rdPend_d = rdPend_q;
    awDone_d = awDone_q;
    wDone_d  = wDone_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_w_ena || req_r_ena) begin
          err_d    = 1'b0;
          rdPend_d = req_r_ena;
          awDone_d = 1'b0;
          wDone_d  = 1'b0;
          if (req_r_ena) raddr_d = req_raddr;
          if (req_w_ena) begin
            waddr_d = req_waddr;
            wdata_d = req_wdata;
            state_d = WREQ;
          end else begin
            state_d = RREQ;
          end
        end
      end
      WREQ: begin
        awDone_d = awDoneNext;
        wDone_d  = wDoneNext;
        if (awDoneNext && wDoneNext) state_d = WRESP;
        else if (timeout)            state_d = rdPend_q ? DONE : IDLE;
      end
      WRESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          state_d = rdPend_q ? RREQ : IDLE;
        end else if (timeout) begin
          state_d = rdPend_q ? DONE : IDLE;
        end
      end
      RREQ: begin
        if (arready)      state_d = RRESP;
        else if (timeout) state_d = DONE;
      end
      RRESP: begin
        if (rvalid) begin
          rdata_d = rdata;
          if (rresp != 2'b00) err_d = 1'b1;
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A watchdog abort flags the error and hands the cache zero data instead of a stale line.
    if (timeout && (state_d != state_q)) begin
      err_d = err_d | (state_d != WRESP && state_d != RRESP);
      if (state_d == DONE) rdata_d = '0;
    end
  end

  assign awvalid     = (state_q == WREQ) && !awDone_q;
  assign wvalid      = (state_q == WREQ) && !wDone_q;
  assign bready      = (state_q == WRESP);
  assign arvalid     = (state_q == RREQ);
  assign rready      = (state_q == RRESP);
  assign r_valid_out = (state_q == DONE);
  assign busy_out    = (state_q != IDLE);
  assign err_out     = err_q;
  assign rdata_out   = rdata_q;
  assign awaddr      = waddr_q;
  assign wdata       = wdata_q;
  assign araddr      = raddr_q;
  assign awsize      = 3'b011;
  assign arsize      = 3'b011;
  assign awlen       = 8'h00;
  assign arlen       = 8'h00;
  assign wstrb       = 8'hFF;
  assign wlast       = 1'b1;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Scoreboard bench for cache_axi_bridge: a delay-configurable AXI slave plus a refill monitor.
module tb_cache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_w_ena = 1'b0, req_r_ena = 1'b0;
  logic [63:0] req_waddr = '0, req_wdata = '0, req_raddr = '0;
  logic [63:0] rdata_out;
  logic        r_valid_out, busy_out, err_out;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast;
  logic [63:0] awaddr, wdata, araddr;
  logic [2:0]  awsize, arsize;
  logic [7:0]  awlen, arlen, wstrb;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [63:0] rdata = '0;

  cache_axi_bridge #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_w_ena(req_w_ena), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_r_ena(req_r_ena), .req_raddr(req_raddr),
    .rdata_out(rdata_out), .r_valid_out(r_valid_out), .busy_out(busy_out), .err_out(err_out),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          reqCyc;
  } exp_t;

  exp_t        expQ[$];
  logic [63:0] expAwQ[$], expWQ[$], expArQ[$];
  int          checksTotal = 0, checksPassed = 0;
  int          cyc = 0;
  int          awDelay = 0, wDelay = 0, arDelay = 0, rDelay = 0;
  logic [1:0]  rRespCfg = 2'b00;
  logic [63:0] rDataCfg = '0;
  bit          wrPending = 0, t3Active = 0, overlapSeen = 0, prevRv = 0;
  int          arvCount = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc++;

  // Slave: state updated from pre-edge handshakes, outputs driven 1 time unit after the edge.
  int awHeld = 0, wHeld = 0, arHeld = 0, rWait = 0;
  bit awSeen = 0, wSeen = 0, rPend = 0, bS = 0, rS = 0;
  always begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      awHeld = 0; wHeld = 0; arHeld = 0; rWait = 0;
      awSeen = 0; wSeen = 0; rPend = 0; bS = 0; rS = 0;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    end else begin
      if (awvalid && awready) begin
        checkOutput("awaddr", awaddr, expAwQ.size() != 0 ? expAwQ.pop_front() : 64'hDEAD);
        checkOutput("awsize", 64'(awsize), 64'd3);
        if (t3Active) begin
          checkOutput("t3WFirst", 64'(wSeen), 64'd1);
          checkOutput("t3WvalidDropped", 64'(wvalid), 64'd0);
          checkOutput("t3NoBreadyYet", 64'(bready), 64'd0);
        end
        awSeen = 1; awHeld = 0;
      end else if (awvalid) awHeld++;
      if (wvalid && wready) begin
        checkOutput("wdata", wdata, expWQ.size() != 0 ? expWQ.pop_front() : 64'hDEAD);
        checkOutput("wstrb", 64'(wstrb), 64'hFF);
        wSeen = 1; wHeld = 0;
      end else if (wvalid) wHeld++;
      if (bS && bready) begin bS = 0; wrPending = 0; end
      if (awSeen && wSeen) begin bS = 1; awSeen = 0; wSeen = 0; end
      if (arvalid && arready) begin
        checkOutput("araddr", araddr, expArQ.size() != 0 ? expArQ.pop_front() : 64'hDEAD);
        checkOutput("arAfterB", 64'(wrPending), 64'd0);
        rPend = 1; rWait = 0; arHeld = 0;
      end else if (arvalid) arHeld++;
      if (rS && rready) rS = 0;
      if (rPend) begin
        if (rWait >= rDelay) begin rS = 1; rPend = 0; end
        else rWait++;
      end
      #1;
      if (rst) begin
        bvalid  = bS;
        bresp   = 2'b00;
        rvalid  = rS;
        rdata   = rS ? rDataCfg : 64'h0;
        rresp   = rS ? rRespCfg : 2'b00;
        awready = awvalid && (awHeld >= awDelay);
        wready  = wvalid && (wHeld >= wDelay);
        arready = arvalid && (arHeld >= arDelay);
      end
    end
  end

  // Refill monitor: pops the scoreboard on each r_valid_out pulse.
  always @(negedge clk) begin
    if (wvalid && arvalid) overlapSeen = 1;
    if (arvalid) arvCount++;
    if (prevRv) checkOutput("rvPulseWidth", 64'(r_valid_out), 64'd0);
    if (r_valid_out && !prevRv) begin
      if (expQ.size() == 0) checkOutput("rvUnexpected", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rdataOut", rdata_out, e.rdata);
        checkOutput("errOut", 64'(err_out), 64'(e.err));
        if (e.lat != 0) checkOutput("latency", 64'(cyc - e.reqCyc + 1), 64'(e.lat));
      end
    end
    prevRv = r_valid_out;
  end

  task automatic applyStimulus(input bit w, input logic [63:0] wa, input logic [63:0] wd,
                               input bit r, input logic [63:0] ra,
                               input logic [63:0] expData, input bit expErr, input int lat);
    exp_t e;
    @(negedge clk);
    req_w_ena = w; req_waddr = wa; req_wdata = wd;
    req_r_ena = r; req_raddr = ra;
    if (w) begin expAwQ.push_back(wa); expWQ.push_back(wd); wrPending = 1; end
    if (r) begin
      expArQ.push_back(ra);
      e.rdata = expData; e.err = expErr; e.lat = lat; e.reqCyc = cyc;
      expQ.push_back(e);
    end
    @(negedge clk);
    req_w_ena = 0; req_r_ena = 0;
  endtask

  task automatic waitIdle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy_out && expQ.size() == 0) done = 1;
    end
    if (!done) checkOutput("waitIdleTimeout", 64'd1, 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("rstBusy", 64'(busy_out), 64'd0);
    checkOutput("rstValids", 64'({awvalid, wvalid, arvalid, bready, rready, r_valid_out}), 64'd0);
    checkOutput("rstErr", 64'(err_out), 64'd0);
    checkOutput("rstRdata", rdata_out, 64'd0);
    @(negedge clk); rst = 1;

    // Read with a slow AR channel
    arDelay = 2; rDataCfg = 64'h1122_3344_5566_7788;
    applyStimulus(0, 0, 0, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, 0);
    checkOutput("busyAfterReq", 64'(busy_out), 64'd1);
    waitIdle(100);
    checkOutput("rdataHeld", rdata_out, 64'h1122_3344_5566_7788);

    // Zero-wait read-only latency
    arDelay = 0; rDataCfg = 64'hA5A5_0000_1111_2222;
    applyStimulus(0, 0, 0, 1, 64'h8000_0100, 64'hA5A5_0000_1111_2222, 0, 4);
    waitIdle(100);

    // Write-back and refill together
    overlapSeen = 0; rDataCfg = 64'h0BAD_CAFE_0000_0042;
    applyStimulus(1, 64'h4000_0008, 64'hFEED_FACE_DEAD_BEEF, 1, 64'h4000_0200,
                  64'h0BAD_CAFE_0000_0042, 0, 6);
    waitIdle(100);
    checkOutput("t2NoWArOverlap", 64'(overlapSeen), 64'd0);

    // W completes three cycles before AW
    t3Active = 1; awDelay = 3; wDelay = 0;
    applyStimulus(1, 64'h4000_0040, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0);
    waitIdle(100);
    t3Active = 0; awDelay = 0;
    checkOutput("t3ErrClear", 64'(err_out), 64'd0);

    // Refill with SLVERR still completes
    rRespCfg = 2'b10; rDataCfg = 64'h7777_6666_5555_4444;
    applyStimulus(0, 0, 0, 1, 64'h8000_0300, 64'h7777_6666_5555_4444, 1, 0);
    waitIdle(100);
    rRespCfg = 2'b00;
    checkOutput("t4ErrHeld", 64'(err_out), 64'd1);
    rDataCfg = 64'h0000_0000_0000_9999;
    applyStimulus(0, 0, 0, 1, 64'h8000_0308, 64'h0000_0000_0000_9999, 0, 0);
    checkOutput("t4ErrClearedOnAccept", 64'(err_out), 64'd0);
    waitIdle(100);

    // Reset while waiting in RRESP
    rDelay = 6;
    applyStimulus(0, 0, 0, 1, 64'h8000_0400, 64'h0, 0, 0);
    for (int i = 0; i < 20 && !rready; i++) @(negedge clk);
    checkOutput("t5InRresp", 64'(rready), 64'd1);
    #2 rst = 0;
    #1;
    checkOutput("t5RstValids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    checkOutput("t5RstBusyRv", 64'({busy_out, r_valid_out}), 64'd0);
    expQ.delete(); expArQ.delete(); expAwQ.delete(); expWQ.delete(); wrPending = 0;
    rDelay = 0;
    @(negedge clk); rst = 1;
    rDataCfg = 64'h5151_5151_5151_5151;
    applyStimulus(0, 0, 0, 1, 64'h8000_0500, 64'h5151_5151_5151_5151, 0, 4);
    waitIdle(100);

`ifdef CACHE_AXI_TIMEOUT_EN
    // AR never accepted: watchdog aborts and returns zero data
    arDelay = 1000; arvCount = 0; rDataCfg = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(0, 0, 0, 1, 64'h8000_0600, 64'h0, 1, 0);
    waitIdle(100);
    checkOutput("t6ArvalidCycles", 64'(arvCount), 64'd16);
    expArQ.delete(); arDelay = 0;
`endif

    checkOutput("finalIdle", 64'(busy_out), 64'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
